// File: rtl/mipi_dsi_pkg.sv
// Shared definitions for the DSI HS packet parser: FSM states, DT codes, long-packet test.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mipi_dsi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_HDR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CRC     = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    // Data types seen on the link (6-bit DT field of the DI byte)
    localparam logic [5:0] DT_DCS_SHORT_WR   = 6'h05;
    localparam logic [5:0] DT_DCS_SHORT_WR_P = 6'h15;
    localparam logic [5:0] DT_DCS_LONG_WR    = 6'h39;
    localparam logic [5:0] DT_RGB888_PACKED  = 6'h3E;
    localparam logic [5:0] DT_EOTP           = 6'h08;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hB8;
    localparam logic [15:0] MAX_WC_DEFAULT    = 16'd4096;

    // Long packets have DT[3] set and a non-zero low field; 0x08 (EoTp) stays short.
    function automatic logic is_long_dt(input logic [5:0] dt);
        return dt[3] && (dt[2:0] != 3'b000);
    endfunction

endpackage

// File: rtl/mipi_dsi_hs_packet_parser.sv
// Splits a lane-0 HS byte stream into DSI packets: header report, payload stream, CRC capture, errors.
// Latency: every output registered, one cycle after the accepted byte.
// Backpressure: none; bytes are consumed whenever hs_byte_valid is high.
// Ports: sys_clk/sys_rst_n; hs_burst_flag + hs_byte_data/hs_byte_valid in;
//        hdr_valid/pkt_di/pkt_wc/pkt_ecc/pkt_long, pay_data/pay_valid/pay_last,
//        crc_valid/pkt_crc, sync_err/hdr_err/trunc_err out.
module mipi_dsi_hs_packet_parser
    import mipi_dsi_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter logic [15:0] MAX_WC    = MAX_WC_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        hs_burst_flag,
    input  logic [7:0]  hs_byte_data,
    input  logic        hs_byte_valid,
    output logic        hdr_valid,
    output logic [7:0]  pkt_di,
    output logic [15:0] pkt_wc,
    output logic [7:0]  pkt_ecc,
    output logic        pkt_long,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        pay_last,
    output logic        crc_valid,
    output logic [15:0] pkt_crc,
    output logic        sync_err,
    output logic        hdr_err,
    output logic        trunc_err
);

    state_t      state;
    logic [1:0]  byte_idx;   // header byte index in HDR, CRC byte index in CRC
    logic [15:0] pay_cnt;    // payload bytes still to come
    logic        burst_q;
    logic [7:0]  di_r;
    logic [7:0]  wc_lo_r;
    logic [7:0]  wc_hi_r;
    logic [7:0]  crc_lo_r;

    logic        burst_rise;
    logic        burst_fall;
    logic [15:0] hdr_wc;
    logic        hdr_long;

    assign burst_rise = hs_burst_flag & ~burst_q;
    assign burst_fall = ~hs_burst_flag & burst_q;
    assign hdr_wc     = {wc_hi_r, wc_lo_r};
    assign hdr_long   = is_long_dt(di_r[5:0]);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            byte_idx  <= 2'd0;
            pay_cnt   <= 16'd0;
            burst_q   <= 1'b0;
            di_r      <= 8'd0;
            wc_lo_r   <= 8'd0;
            wc_hi_r   <= 8'd0;
            crc_lo_r  <= 8'd0;
            hdr_valid <= 1'b0;
            pkt_di    <= 8'd0;
            pkt_wc    <= 16'd0;
            pkt_ecc   <= 8'd0;
            pkt_long  <= 1'b0;
            pay_data  <= 8'd0;
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
            crc_valid <= 1'b0;
            pkt_crc   <= 16'd0;
            sync_err  <= 1'b0;
            hdr_err   <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            burst_q   <= hs_burst_flag;
            hdr_valid <= 1'b0;
            pay_valid <= 1'b0;
            pay_last  <= 1'b0;
            crc_valid <= 1'b0;
            sync_err  <= 1'b0;
            hdr_err   <= 1'b0;
            trunc_err <= 1'b0;

            if (burst_fall) begin
                // Fall beats any byte in the same cycle; that byte is dropped.
                trunc_err <= ((state == ST_HDR) && (byte_idx != 2'd0)) ||
                             (state == ST_PAYLOAD) || (state == ST_CRC);
                state     <= ST_IDLE;
                byte_idx  <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Bytes during the rise cycle are ignored; sync must follow.
                        if (burst_rise) begin
                            state <= ST_SYNC;
                        end
                    end

                    ST_SYNC: begin
                        if (hs_byte_valid) begin
                            byte_idx <= 2'd0;
                            if (hs_byte_data == SYNC_BYTE) begin
                                state <= ST_HDR;
                            end else begin
                                sync_err <= 1'b1;
                                state    <= ST_DRAIN;
                            end
                        end
                    end

                    ST_HDR: begin
                        if (hs_byte_valid) begin
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0: di_r    <= hs_byte_data;
                                2'd1: wc_lo_r <= hs_byte_data;
                                2'd2: wc_hi_r <= hs_byte_data;
                                default: begin
                                    hdr_valid <= 1'b1;
                                    pkt_di    <= di_r;
                                    pkt_wc    <= hdr_wc;
                                    pkt_ecc   <= hs_byte_data;
                                    pkt_long  <= hdr_long;
                                    if (hdr_long) begin
                                        if (hdr_wc > MAX_WC) begin
                                            hdr_err <= 1'b1;
                                            state   <= ST_DRAIN;
                                        end else if (hdr_wc == 16'd0) begin
                                            state <= ST_CRC;
                                        end else begin
                                            pay_cnt <= hdr_wc;
                                            state   <= ST_PAYLOAD;
                                        end
                                    end
                                end
                            endcase
                        end
                    end

                    ST_PAYLOAD: begin
                        if (hs_byte_valid) begin
                            pay_data  <= hs_byte_data;
                            pay_valid <= 1'b1;
                            pay_cnt   <= pay_cnt - 16'd1;
                            if (pay_cnt == 16'd1) begin
                                pay_last <= 1'b1;
                                byte_idx <= 2'd0;
                                state    <= ST_CRC;
                            end
                        end
                    end

                    ST_CRC: begin
                        if (hs_byte_valid) begin
                            if (byte_idx == 2'd0) begin
                                crc_lo_r <= hs_byte_data;
                                byte_idx <= 2'd1;
                            end else begin
                                pkt_crc   <= {hs_byte_data, crc_lo_r};
                                crc_valid <= 1'b1;
                                byte_idx  <= 2'd0;
                                state     <= ST_HDR;
                            end
                        end
                    end

                    ST_DRAIN: begin
                        if (!hs_burst_flag) begin
                            state <= ST_IDLE;
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        byte_idx <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mipi_dsi_hs_packet_parser.sv
// Directed bench for the DSI HS packet parser with hand-computed expectations.
// Latency: outputs are checked 1 time unit after the edge that registers each byte.
// Backpressure: n/a.
module tb_mipi_dsi_hs_packet_parser;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        hs_burst_flag;
    logic [7:0]  hs_byte_data;
    logic        hs_byte_valid;
    logic        hdr_valid;
    logic [7:0]  pkt_di;
    logic [15:0] pkt_wc;
    logic [7:0]  pkt_ecc;
    logic        pkt_long;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_last;
    logic        crc_valid;
    logic [15:0] pkt_crc;
    logic        sync_err;
    logic        hdr_err;
    logic        trunc_err;

    int n_chk  = 0;
    int n_fail = 0;

    mipi_dsi_hs_packet_parser dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .hs_burst_flag (hs_burst_flag),
        .hs_byte_data  (hs_byte_data),
        .hs_byte_valid (hs_byte_valid),
        .hdr_valid     (hdr_valid),
        .pkt_di        (pkt_di),
        .pkt_wc        (pkt_wc),
        .pkt_ecc       (pkt_ecc),
        .pkt_long      (pkt_long),
        .pay_data      (pay_data),
        .pay_valid     (pay_valid),
        .pay_last      (pay_last),
        .crc_valid     (crc_valid),
        .pkt_crc       (pkt_crc),
        .sync_err      (sync_err),
        .hdr_err       (hdr_err),
        .trunc_err     (trunc_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; returns 1 unit after the edge that registers them.
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        hs_byte_valid = v;
        hs_byte_data  = d;
        hs_burst_flag = f;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b1);
    endtask

    task automatic start_burst();
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic end_burst();
        step(1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [63:0] all_outs();
        return {hdr_valid, pkt_di, pkt_wc, pkt_ecc, pkt_long, pay_data, pay_valid,
                pay_last, crc_valid, pkt_crc, sync_err, hdr_err, trunc_err};
    endfunction

    function automatic logic [2:0] errs();
        return {sync_err, hdr_err, trunc_err};
    endfunction

    initial begin
        sys_rst_n     = 1'b0;
        hs_burst_flag = 1'b0;
        hs_byte_data  = 8'h00;
        hs_byte_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        sys_rst_n = 1'b1;
        end_burst();

        // Short DCS write 05 2C 00
        start_burst();
        send(8'hB8);
        chk("t1_no_hdr_on_sync", {63'd0, hdr_valid}, 64'd0);
        send(8'h05);
        send(8'h2C);
        send(8'h00);
        send(8'h7A);
        chk("t1_hdr_valid", {63'd0, hdr_valid}, 64'd1);
        chk("t1_fields", {24'd0, pkt_di, pkt_wc, pkt_ecc, 7'd0, pkt_long}, {24'd0, 8'h05, 16'h002C, 8'h7A, 8'h00});
        chk("t1_errs", {61'd0, errs()}, 64'd0);
        end_burst();
        chk("t1_clean_end", {60'd0, hdr_valid, errs()}, 64'd0);
        end_burst();

        // Long DCS write, 3 payload bytes, CRC 0x1234
        start_burst();
        send(8'hB8);
        send(8'h39);
        send(8'h03);
        send(8'h00);
        send(8'h11);
        chk("t2_hdr", {39'd0, hdr_valid, pkt_di, pkt_wc, pkt_long}, {39'd0, 1'b1, 8'h39, 16'h0003, 1'b1});
        send(8'hAA);
        chk("t2_pay0", {54'd0, pay_valid, pay_last, pay_data}, {54'd0, 1'b1, 1'b0, 8'hAA});
        send(8'hBB);
        chk("t2_pay1", {54'd0, pay_valid, pay_last, pay_data}, {54'd0, 1'b1, 1'b0, 8'hBB});
        send(8'hCC);
        chk("t2_pay2_last", {54'd0, pay_valid, pay_last, pay_data}, {54'd0, 1'b1, 1'b1, 8'hCC});
        send(8'h34);
        chk("t2_crc_lo_no_pulse", {62'd0, crc_valid, pay_valid}, 64'd0);
        send(8'h12);
        chk("t2_crc", {47'd0, crc_valid, pkt_crc}, {47'd0, 1'b1, 16'h1234});
        end_burst();
        chk("t2_clean_end", {61'd0, errs()}, 64'd0);
        end_burst();

        // Two packets in one burst: short 15, then long 3E WC=2
        start_burst();
        send(8'hB8);
        send(8'h15);
        send(8'h55);
        send(8'h66);
        send(8'h01);
        chk("t3_hdr_short", {39'd0, hdr_valid, pkt_di, pkt_wc, pkt_long}, {39'd0, 1'b1, 8'h15, 16'h6655, 1'b0});
        send(8'h3E);
        chk("t3_gap", {63'd0, hdr_valid}, 64'd0);
        send(8'h02);
        send(8'h00);
        send(8'h02);
        chk("t3_hdr_long", {39'd0, hdr_valid, pkt_di, pkt_wc, pkt_long}, {39'd0, 1'b1, 8'h3E, 16'h0002, 1'b1});
        send(8'h5A);
        chk("t3_pay0", {54'd0, pay_valid, pay_last, pay_data}, {54'd0, 1'b1, 1'b0, 8'h5A});
        // An idle cycle inside the payload must not advance anything
        step(1'b0, 8'hFF, 1'b1);
        chk("t3_idle", {63'd0, pay_valid}, 64'd0);
        send(8'hA5);
        chk("t3_pay1_last", {54'd0, pay_valid, pay_last, pay_data}, {54'd0, 1'b1, 1'b1, 8'hA5});
        send(8'h78);
        send(8'h56);
        chk("t3_crc", {47'd0, crc_valid, pkt_crc}, {47'd0, 1'b1, 16'h5678});
        end_burst();
        end_burst();

        // Bad sync byte, then drain, then a normal burst
        start_burst();
        send(8'h9C);
        chk("t4_sync_err", {61'd0, errs()}, {61'd0, 3'b100});
        send(8'h05);
        chk("t4_sync_err_pulse", {63'd0, sync_err}, 64'd0);
        send(8'h2C);
        send(8'h00);
        send(8'h00);
        chk("t4_no_hdr_in_drain", {63'd0, hdr_valid}, 64'd0);
        end_burst();
        chk("t4_drain_clean_end", {61'd0, errs()}, 64'd0);
        end_burst();
        start_burst();
        send(8'hB8);
        send(8'h08);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("t4_next_burst_eotp", {39'd0, hdr_valid, pkt_di, pkt_wc, pkt_long}, {39'd0, 1'b1, 8'h08, 16'h0201, 1'b0});
        end_burst();
        end_burst();

        // Truncation after 1 of 3 payload bytes; byte on the fall cycle is discarded
        start_burst();
        send(8'hB8);
        send(8'h39);
        send(8'h03);
        send(8'h00);
        send(8'h22);
        send(8'hAA);
        chk("t5_pay0", {63'd0, pay_valid}, 64'd1);
        step(1'b1, 8'hBB, 1'b0);
        chk("t5_trunc", {62'd0, trunc_err, pay_valid}, {62'd0, 2'b10});
        end_burst();
        chk("t5_trunc_pulse", {63'd0, trunc_err}, 64'd0);
        start_burst();
        send(8'hB8);
        send(8'h05);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        chk("t5_next_burst", {31'd0, hdr_valid, pkt_di, pkt_wc, errs(), 5'd0},
            {31'd0, 1'b1, 8'h05, 16'h2010, 3'b000, 5'd0});
        // Fall mid-header also truncates
        send(8'h05);
        end_burst();
        chk("t5_trunc_hdr", {63'd0, trunc_err}, 64'd1);
        end_burst();

        // Oversized WC -> hdr_err with hdr_valid, no payload, drain
        start_burst();
        send(8'hB8);
        send(8'h39);
        send(8'h00);
        send(8'h20);
        send(8'h44);
        chk("t6_hdr_err", {46'd0, hdr_valid, hdr_err, pkt_wc}, {46'd0, 1'b1, 1'b1, 16'h2000});
        send(8'h01);
        chk("t6_no_pay0", {62'd0, pay_valid, hdr_err}, 64'd0);
        send(8'h02);
        chk("t6_no_pay1", {63'd0, pay_valid}, 64'd0);
        end_burst();
        chk("t6_drain_end", {61'd0, errs()}, 64'd0);
        end_burst();

        // WC exactly MAX_WC accepted; WC=0 goes straight to CRC
        start_burst();
        send(8'hB8);
        send(8'h3E);
        send(8'h00);
        send(8'h10);
        send(8'h55);
        chk("t7_max_wc_ok", {46'd0, hdr_valid, hdr_err, pkt_wc}, {46'd0, 1'b1, 1'b0, 16'h1000});
        send(8'h01);
        chk("t7_max_wc_pay", {62'd0, pay_valid, pay_last}, {62'd0, 2'b10});
        end_burst();
        chk("t7_trunc_payload", {63'd0, trunc_err}, 64'd1);
        end_burst();
        start_burst();
        send(8'hB8);
        send(8'h39);
        send(8'h00);
        send(8'h00);
        send(8'h66);
        chk("t7_wc0_hdr", {46'd0, hdr_valid, pkt_long, pkt_wc}, {46'd0, 1'b1, 1'b1, 16'h0000});
        send(8'hEF);
        chk("t7_wc0_no_pay", {62'd0, pay_valid, crc_valid}, 64'd0);
        send(8'hBE);
        chk("t7_wc0_crc", {46'd0, crc_valid, pay_valid, pkt_crc}, {46'd0, 1'b1, 1'b0, 16'hBEEF});
        end_burst();

        // Asynchronous reset mid-payload
        start_burst();
        send(8'hB8);
        send(8'h39);
        send(8'h03);
        send(8'h00);
        send(8'h77);
        send(8'hAA);
        chk("t8_pre_reset_pay", {63'd0, pay_valid}, 64'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t8_async_reset", all_outs(), 64'd0);
        @(posedge sys_clk);
        #1;
        chk("t8_no_err_after_reset", {61'd0, errs()}, 64'd0);
        hs_burst_flag = 1'b0;
        hs_byte_valid = 1'b0;
        sys_rst_n     = 1'b1;
        end_burst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
